collision_game_ctrl: RTL and testbench
======================================

# collision_game_ctrl

Downstream consumer of the moving-obstacle pixel stream. Each pixel it compares the registered obstacle colour and level with the player-car pixel and flags overlaps. Once per frame it runs the game-state machine (IDLE, RUN, CRASH, GAME_OVER), counts lives, and drives a freeze request back to the motion logic. It also produces the final obstacle-layer pixel, with crash highlighting and game-over dimming, for the video mux.

## Interface
Parameters:
- H_LAST, 639, last visible column; together with V_LAST it defines frame end
- V_LAST, 479, last visible row
- START_LIVES, 3, lives loaded on game start (1..3)
- CRASH_FRAMES, 60, frames spent in CRASH (1..255)
- HIT_COLOR, 12'hF00, colour painted on overlapping pixels during CRASH

Ports:
- clk  in  1  system clock (100 MHz); pixel coordinates may hold for several clk cycles
- reset_n  in  1  asynchronous, active-low reset
- pix_row, pix_col  in  10 each  current pixel from the display timing generator
- video_on  in  1  visible-region flag from the display timing generator
- moving_cars_in  in  12  registered obstacle pixel; 12'h000 means no obstacle
- level_in  in  2  current level from the obstacle block
- player_car_in  in  12  player-car sprite pixel; 12'h000 means transparent
- start  in  1  debounced start button, single-cycle pulse
- game_state  out  2  00 IDLE, 01 RUN, 10 CRASH, 11 GAME_OVER
- lives  out  2  remaining lives
- freeze  out  1  high: obstacle and lane motion must hold position
- max_level  out  2  highest level_in seen in the current game
- obstacle_out  out  12  processed obstacle-layer pixel, 1-cycle latency

## Operation
- Overlap condition: `video_on && moving_cars_in != 0 && player_car_in != 0`, evaluated every clk.
  - hit_frame is a sticky flag set by overlap.
  - hit_frame clears on the cycle after frame_end.
- frame_end is a one-cycle pulse. It fires on the first clk where pix_row==V_LAST and pix_col==H_LAST, and the previous clk's coordinates differed. This gives exactly one pulse per frame regardless of how long each coordinate is held.
- FSM:
  - IDLE: lives=START_LIVES, max_level=0, freeze=1. start → RUN.
  - RUN: freeze=0. On frame_end with hit_frame=1: lives decrements, crash_cnt loads CRASH_FRAMES-1, state → CRASH.
  - CRASH: freeze=1. Each frame_end decrements crash_cnt. On frame_end with crash_cnt==0: lives==0 → GAME_OVER, else → RUN.
  - GAME_OVER: freeze=1. start → IDLE. Lives are reloaded in IDLE.
- start is ignored in RUN and CRASH.
- start pulsing in IDLE on the same cycle as frame_end: the transition to RUN wins, and that frame's hit_frame is discarded.
- lives saturates at 0 and never wraps.
- max_level: in RUN, on each clk it becomes level_in when level_in > max_level. It holds in other states.
- obstacle_out (registered):
  - RUN and IDLE: moving_cars_in.
  - CRASH: HIT_COLOR where overlap=1 and crash_cnt[3]=1 (blink); otherwise moving_cars_in.
  - GAME_OVER: each 4-bit channel of moving_cars_in shifted right by 1.

## Timing
- Reset values: game_state=IDLE, lives=START_LIVES, freeze=1, max_level=0, obstacle_out=0. Internal state also resets: crash_cnt=0, hit_frame=0, previous-coordinate registers=0.
- Reset asserted mid-game forces all of the above immediately (asynchronous). Release is synchronous to clk. The first frame_end after release is not processed until the FSM sees start.
- game_state, lives and freeze update on the clk edge following frame_end (or start). freeze therefore changes exactly at frame boundaries.
- obstacle_out latency is 1 clk from moving_cars_in, player_car_in and pix_*.
- An overlap on the pixel at (V_LAST, H_LAST) in the same cycle as frame_end still counts for that frame.

## Test plan
- Run with a single hit:
  - Stimulus: reset, start pulse, then a frame with one overlapping pixel at (200,300) with moving_cars_in=12'h0F0 and player_car_in=12'h00F.
  - Required: the clk after frame_end shows game_state=10, lives=2, freeze=1. obstacle_out at (200,300) is 12'hF00 when crash_cnt[3]=1.
- CRASH recovery:
  - Stimulus: hold CRASH with no overlaps for CRASH_FRAMES=60 frame_ends.
  - Required: state returns to 01 after exactly 60 frames and freeze drops to 0.
- Game over:
  - Stimulus: three hit frames, each separated by a full CRASH period.
  - Required: lives=0, state=11, and moving_cars_in=12'hEEE appears as 12'h777. A start pulse then gives state 00 with lives=3.
- Held coordinates:
  - Stimulus: hold pix=(479,639) for 4 clk.
  - Required: exactly one frame_end, and lives decrements by exactly 1.
- Asynchronous reset in CRASH:
  - Stimulus: assert reset_n low while state=10, between clock edges.
  - Required: outputs return to reset values without waiting for a clk edge.
- max_level tracking:
  - Stimulus: in RUN, step level_in through 0,1,3,2.
  - Required: max_level=3. It holds at 3 through CRASH and returns to 0 in IDLE.

Source files
------------

// File: rtl/collision_game_ctrl.sv
// Purpose: per-pixel obstacle/player overlap detection, once-per-frame game FSM, lives, freeze and obstacle-layer pixel.
// Latency: obstacle_out is registered (1 clk); game_state/lives/freeze change on the clk edge after frame_end or start.
// Backpressure: none; a pure pixel-stream consumer. Backpressure to the motion logic is the freeze level.
//
// Ports:
//   clk, reset_n              clock, async active-low reset
//   pix_row, pix_col          current pixel coordinates (may be held for several clk)
//   video_on                  visible-region flag
//   moving_cars_in            obstacle pixel (0 = none)
//   level_in                  current obstacle level
//   player_car_in             player sprite pixel (0 = transparent)
//   start                     single-cycle start pulse
//   game_state                00 IDLE, 01 RUN, 10 CRASH, 11 GAME_OVER
//   lives                     remaining lives
//   freeze                    hold obstacle/lane motion
//   max_level                 highest level seen this game
//   obstacle_out              processed obstacle-layer pixel
module collision_game_ctrl #(
   parameter int          H_LAST       = 639,
   parameter int          V_LAST       = 479,
   parameter int          START_LIVES  = 3,
   parameter int          CRASH_FRAMES = 60,
   parameter logic [11:0] HIT_COLOR    = 12'hF00
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [9:0]  pix_row,
   input  logic [9:0]  pix_col,
   input  logic        video_on,
   input  logic [11:0] moving_cars_in,
   input  logic [1:0]  level_in,
   input  logic [11:0] player_car_in,
   input  logic        start,
   output logic [1:0]  game_state,
   output logic [1:0]  lives,
   output logic        freeze,
   output logic [1:0]  max_level,
   output logic [11:0] obstacle_out
);

   localparam logic [9:0] ROW_LAST   = 10'(V_LAST);
   localparam logic [9:0] COL_LAST   = 10'(H_LAST);
   localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
   localparam logic [7:0] CRASH_LOAD = 8'(CRASH_FRAMES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_CRASH = 2'b10,
      S_OVER  = 2'b11
   } state_t;

   state_t      state;
   logic [7:0]  crash_cnt;
   logic        hit_frame;
   logic [9:0]  prev_row;
   logic [9:0]  prev_col;

   logic overlap;
   logic at_last;
   logic prev_at_last;
   logic frame_end;
   logic hit_now;

   assign overlap      = video_on && (moving_cars_in != 12'h000) && (player_car_in != 12'h000);
   assign at_last      = (pix_row == ROW_LAST) && (pix_col == COL_LAST);
   assign prev_at_last = (prev_row == ROW_LAST) && (prev_col == COL_LAST);
   // Edge-detect on the last pixel so held coordinates give a single pulse.
   assign frame_end    = at_last && !prev_at_last;
   // An overlap on the frame's final pixel still belongs to this frame.
   assign hit_now      = hit_frame || overlap;

   assign game_state = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         lives        <= LIVES_INIT;
         freeze       <= 1'b1;
         max_level    <= 2'd0;
         obstacle_out <= 12'h000;
         crash_cnt    <= 8'd0;
         hit_frame    <= 1'b0;
         prev_row     <= 10'd0;
         prev_col     <= 10'd0;
      end else begin
         prev_row <= pix_row;
         prev_col <= pix_col;

         // Starting a game discards whatever was accumulated while idle.
         if (frame_end || (state == S_IDLE && start))
            hit_frame <= 1'b0;
         else if (overlap)
            hit_frame <= 1'b1;

         case (state)
            S_IDLE: begin
               lives     <= LIVES_INIT;
               max_level <= 2'd0;
               freeze    <= 1'b1;
               if (start) begin
                  state  <= S_RUN;
                  freeze <= 1'b0;
               end
            end
            S_RUN: begin
               if (level_in > max_level)
                  max_level <= level_in;
               if (frame_end && hit_now) begin
                  lives     <= (lives == 2'd0) ? 2'd0 : lives - 2'd1;
                  crash_cnt <= CRASH_LOAD;
                  state     <= S_CRASH;
                  freeze    <= 1'b1;
               end
            end
            S_CRASH: begin
               if (frame_end) begin
                  if (crash_cnt == 8'd0) begin
                     if (lives == 2'd0) begin
                        state <= S_OVER;
                     end else begin
                        state  <= S_RUN;
                        freeze <= 1'b0;
                     end
                  end else begin
                     crash_cnt <= crash_cnt - 8'd1;
                  end
               end
            end
            S_OVER: begin
               if (start) begin
                  state     <= S_IDLE;
                  lives     <= LIVES_INIT;
                  max_level <= 2'd0;
               end
            end
            default: state <= S_IDLE;
         endcase

         case (state)
            // crash_cnt[3] toggles every 8 frames, giving the blink.
            S_CRASH: obstacle_out <= (overlap && crash_cnt[3]) ? HIT_COLOR : moving_cars_in;
            S_OVER:  obstacle_out <= {1'b0, moving_cars_in[11:9],
                                      1'b0, moving_cars_in[7:5],
                                      1'b0, moving_cars_in[3:1]};
            default: obstacle_out <= moving_cars_in;
         endcase
      end
   end

endmodule

// File: tb/tb_collision_game_ctrl.sv
// Purpose: directed self-checking bench for collision_game_ctrl using short synthetic frames.
// Latency: outputs sampled 1 time unit after each rising clk edge.
// Backpressure: not applicable.
module tb_collision_game_ctrl;

   logic        clk;
   logic        reset_n;
   logic [9:0]  pix_row;
   logic [9:0]  pix_col;
   logic        video_on;
   logic [11:0] moving_cars_in;
   logic [1:0]  level_in;
   logic [11:0] player_car_in;
   logic        start;
   logic [1:0]  game_state;
   logic [1:0]  lives;
   logic        freeze;
   logic [1:0]  max_level;
   logic [11:0] obstacle_out;

   int n_checks = 0;
   int n_errors = 0;

   collision_game_ctrl dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .pix_row        (pix_row),
      .pix_col        (pix_col),
      .video_on       (video_on),
      .moving_cars_in (moving_cars_in),
      .level_in       (level_in),
      .player_car_in  (player_car_in),
      .start          (start),
      .game_state     (game_state),
      .lives          (lives),
      .freeze         (freeze),
      .max_level      (max_level),
      .obstacle_out   (obstacle_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int r, input int c, input logic [11:0] mc, input logic [11:0] pc);
      pix_row        = 10'(r);
      pix_col        = 10'(c);
      moving_cars_in = mc;
      player_car_in  = pc;
   endtask

   // Compressed frame: one body pixel, the last pixel (frame_end), then back to origin.
   task automatic frame(input logic hit);
      drive(200, 300, 12'h0F0, hit ? 12'h00F : 12'h000);
      step();
      drive(479, 639, 12'h000, 12'h000);
      step();
      drive(0, 0, 12'h000, 12'h000);
      step();
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame(1'b0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      reset_n  = 1'b0;
      video_on = 1'b1;
      level_in = 2'd0;
      start    = 1'b0;
      drive(0, 0, 12'h000, 12'h000);
      #12;
      check("rst_state",  12'(game_state), 12'h0);
      check("rst_lives",  12'(lives),      12'h3);
      check("rst_freeze", 12'(freeze),     12'h1);
      check("rst_max",    12'(max_level),  12'h0);
      check("rst_obs",    obstacle_out,    12'h000);
      @(negedge clk);
      reset_n = 1'b1;

      // Hits while idle are ignored.
      frame(1'b1);
      check("idle_hold_state", 12'(game_state), 12'h0);
      check("idle_hold_lives", 12'(lives),      12'h3);

      pulse_start();
      check("start_state",  12'(game_state), 12'h1);
      check("start_freeze", 12'(freeze),     12'h0);

      // max_level tracking through 0,1,3,2
      level_in = 2'd0; step();
      level_in = 2'd1; step();
      check("max_after_1", 12'(max_level), 12'h1);
      level_in = 2'd3; step();
      level_in = 2'd2; step();
      check("max_after_2", 12'(max_level), 12'h3);

      drive(10, 10, 12'hABC, 12'h000);
      step();
      check("run_passthru", obstacle_out, 12'hABC);

      // Single hit -> CRASH, crash_cnt = 59 (bit3 = 1)
      frame(1'b1);
      check("hit1_state",  12'(game_state), 12'h2);
      check("hit1_lives",  12'(lives),      12'h2);
      check("hit1_freeze", 12'(freeze),     12'h1);
      check("hit1_max",    12'(max_level),  12'h3);
      drive(200, 300, 12'h0F0, 12'h00F);
      step();
      check("crash_blink_on", obstacle_out, 12'hF00);

      // 4 frames later crash_cnt = 55 (bit3 = 0)
      frames(4);
      drive(200, 300, 12'h0F0, 12'h00F);
      step();
      check("crash_blink_off", obstacle_out, 12'h0F0);
      check("crash_mid_state", 12'(game_state), 12'h2);

      // 59 frame_ends in CRASH so far: still CRASH; the 60th returns to RUN.
      frames(55);
      check("crash59_state",  12'(game_state), 12'h2);
      check("crash59_freeze", 12'(freeze),     12'h1);
      frame(1'b0);
      check("crash60_state",  12'(game_state), 12'h1);
      check("crash60_freeze", 12'(freeze),     12'h0);

      // Overlap on the final pixel, coordinates held for 4 clk.
      drive(479, 639, 12'h0F0, 12'h00F);
      repeat (4) step();
      drive(0, 0, 12'h000, 12'h000);
      step();
      check("held_lives", 12'(lives),      12'h1);
      check("held_state", 12'(game_state), 12'h2);
      frames(60);
      check("held_recover", 12'(game_state), 12'h1);

      // Third hit -> lives 0 -> GAME_OVER after the crash period.
      frame(1'b1);
      check("hit3_lives", 12'(lives),      12'h0);
      check("hit3_state", 12'(game_state), 12'h2);
      frames(60);
      check("over_state",  12'(game_state), 12'h3);
      check("over_lives",  12'(lives),      12'h0);
      check("over_freeze", 12'(freeze),     12'h1);
      check("over_max",    12'(max_level),  12'h3);
      drive(5, 5, 12'hEEE, 12'h000);
      step();
      check("over_dim", obstacle_out, 12'h777);

      pulse_start();
      check("restart_state", 12'(game_state), 12'h0);
      check("restart_lives", 12'(lives),      12'h3);
      check("restart_max",   12'(max_level),  12'h0);

      // New game, one hit, then async reset between clock edges.
      pulse_start();
      frame(1'b1);
      check("g2_state", 12'(game_state), 12'h2);
      check("g2_lives", 12'(lives),      12'h2);
      drive(7, 7, 12'h123, 12'h000);
      step();
      #1;
      reset_n = 1'b0;
      #1;
      check("arst_state",  12'(game_state), 12'h0);
      check("arst_lives",  12'(lives),      12'h3);
      check("arst_freeze", 12'(freeze),     12'h1);
      check("arst_max",    12'(max_level),  12'h0);
      check("arst_obs",    obstacle_out,    12'h000);
      @(negedge clk);
      reset_n = 1'b1;

      // start coinciding with frame_end in IDLE: RUN wins, idle hit discarded.
      drive(200, 300, 12'h0F0, 12'h00F);
      step();
      drive(479, 639, 12'h0F0, 12'h00F);
      start = 1'b1;
      step();
      start = 1'b0;
      drive(0, 0, 12'h000, 12'h000);
      step();
      check("start_fe_state", 12'(game_state), 12'h1);
      frame(1'b0);
      check("start_fe_next_state", 12'(game_state), 12'h1);
      check("start_fe_next_lives", 12'(lives),      12'h3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
